// File: rtl/alarm_pkg.sv
// Shared types and helpers for the alarm scheduler: FSM state encoding,
// BCD time geometry and a lowest-set-bit priority picker.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    localparam int TIME_W  = 16;
    localparam int DIGIT_W = 4;

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        logic       found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (v[i] && !found) begin
                idx   = 4'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/alarm_match_chan.sv
// One alarm channel: BCD time compare, match history, rising-edge event
// detect and the pending flag that holds the event until dispatch.
module alarm_match_chan
    import alarm_pkg::*;
(
    input  logic              clk,
    input  logic              reset_,
    input  logic [TIME_W-1:0] cur_time,
    input  logic [TIME_W-1:0] alarm_time,
    input  logic              en,
    input  logic              dispatch,
    output logic              pending
);

    logic match;
    logic match_q;
    logic digits_eq;

    always_comb begin
        digits_eq = 1'b1;
        for (int unsigned d = 0; d < TIME_W / DIGIT_W; d++) begin
            if (cur_time[d*DIGIT_W +: DIGIT_W] != alarm_time[d*DIGIT_W +: DIGIT_W])
                digits_eq = 1'b0;
        end
        match = en && digits_eq;
    end

    // A fresh event beats a same-cycle dispatch so it is not lost.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            match_q <= 1'b0;
            pending <= 1'b0;
        end else begin
            match_q <= match;
            if (!en)
                pending <= 1'b0;
            else if (match && !match_q)
                pending <= 1'b1;
            else if (dispatch)
                pending <= 1'b0;
        end
    end

endmodule

// File: rtl/alarm_sched.sv
// Multi-channel alarm scheduler: queues per-channel events and services them
// through an IDLE/RINGING/SNOOZE FSM. Snooze is built only with ALARM_SNOOZE_EN.
module alarm_sched
    import alarm_pkg::*;
#(
    parameter  int N_ALARMS   = 4,
    parameter  int RING_MIN   = 3,
    parameter  int SNOOZE_MIN = 5,
    localparam int IDX_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic [TIME_W-1:0]        cur_time,
    input  logic                     min_tick,
    input  logic [TIME_W*N_ALARMS-1:0] alarm_time,
    input  logic [N_ALARMS-1:0]      alarm_en,
    input  logic                     ack,
    input  logic                     snooze,
    output logic                     trigger,
    output logic                     snoozing,
    output logic [IDX_W-1:0]         active_idx,
    output logic [N_ALARMS-1:0]      pending,
    output logic                     timed_out
);

    state_t              state, state_nx;
    logic [IDX_W-1:0]    idx_nx;
    logic [IDX_W-1:0]    first_idx;
    logic [3:0]          ring_cnt, ring_nx;
    logic                tmo_nx;
    logic [N_ALARMS-1:0] dispatch;
`ifdef ALARM_SNOOZE_EN
    logic [3:0]          snz_cnt, snz_nx;
`else
    logic                unused_snooze;
    assign unused_snooze = &{1'b0, snooze, 4'(SNOOZE_MIN)};
`endif

    for (genvar i = 0; i < N_ALARMS; i++) begin : g_chan
        alarm_match_chan u_chan (
            .clk        (clk),
            .reset_     (reset_),
            .cur_time   (cur_time),
            .alarm_time (alarm_time[i*TIME_W +: TIME_W]),
            .en         (alarm_en[i]),
            .dispatch   (dispatch[i]),
            .pending    (pending[i])
        );
    end

    assign first_idx = IDX_W'(lowest_set(16'(pending)));

    always_comb begin
        state_nx = state;
        idx_nx   = active_idx;
        ring_nx  = ring_cnt;
        tmo_nx   = 1'b0;
        dispatch = '0;
`ifdef ALARM_SNOOZE_EN
        snz_nx   = snz_cnt;
`endif
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_nx           = RINGING;
                    idx_nx             = first_idx;
                    ring_nx            = '0;
                    dispatch[first_idx] = 1'b1;
                end
            end
            RINGING: begin
                if (ack || !alarm_en[active_idx]) begin
                    state_nx = IDLE;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze) begin
                    state_nx = SNOOZE;
                    snz_nx   = 4'(SNOOZE_MIN);
`endif
                end else if (min_tick) begin
                    if (5'(ring_cnt) + 5'd1 == 5'(RING_MIN)) begin
                        state_nx = IDLE;
                        tmo_nx   = 1'b1;
                    end else if (ring_cnt != '1) begin
                        ring_nx = ring_cnt + 4'd1;
                    end
                end
            end
`ifdef ALARM_SNOOZE_EN
            SNOOZE: begin
                if (ack || !alarm_en[active_idx]) begin
                    state_nx = IDLE;
                end else if (min_tick) begin
                    if (snz_cnt <= 4'd1) begin
                        state_nx = RINGING;
                        snz_nx   = '0;
                        ring_nx  = '0;
                    end else begin
                        snz_nx = snz_cnt - 4'd1;
                    end
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from next-state so they change with the state flop.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state      <= IDLE;
            ring_cnt   <= '0;
            trigger    <= 1'b0;
            active_idx <= '0;
            timed_out  <= 1'b0;
        end else begin
            state      <= state_nx;
            ring_cnt   <= ring_nx;
            trigger    <= (state_nx == RINGING);
            active_idx <= (state_nx == IDLE) ? '0 : idx_nx;
            timed_out  <= tmo_nx;
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            snz_cnt  <= '0;
            snoozing <= 1'b0;
        end else begin
            snz_cnt  <= snz_nx;
            snoozing <= (state_nx == SNOOZE);
        end
    end
`else
    assign snoozing = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_sched.sv
// Directed table-driven bench for alarm_sched (4 channels, RING_MIN=3,
// SNOOZE_MIN=5); snooze rows follow the ALARM_SNOOZE_EN build option.
module tb_alarm_sched;

    logic        clk;
    logic        reset_;
    logic [15:0] cur_time;
    logic        min_tick;
    logic [63:0] alarm_time;
    logic [3:0]  alarm_en;
    logic        ack;
    logic        snooze;
    logic        trigger;
    logic        snoozing;
    logic [1:0]  active_idx;
    logic [3:0]  pending;
    logic        timed_out;

    int n_checks = 0;
    int n_fail   = 0;

    alarm_sched #(
        .N_ALARMS   (4),
        .RING_MIN   (3),
        .SNOOZE_MIN (5)
    ) dut (
        .clk        (clk),
        .reset_     (reset_),
        .cur_time   (cur_time),
        .min_tick   (min_tick),
        .alarm_time (alarm_time),
        .alarm_en   (alarm_en),
        .ack        (ack),
        .snooze     (snooze),
        .trigger    (trigger),
        .snoozing   (snoozing),
        .active_idx (active_idx),
        .pending    (pending),
        .timed_out  (timed_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] t;
        logic [3:0]  en;
        logic        tick;
        logic        ack;
        logic        snz;
        logic        trig;
        logic [1:0]  idx;
        logic [3:0]  pend;
        logic        tmo;
        logic        snzo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [15:0] t, input logic [3:0] en,
                       input logic tick, input logic a, input logic s,
                       input logic trig, input logic [1:0] idx,
                       input logic [3:0] pend, input logic tmo, input logic snzo);
        vec_t v;
        v.t = t; v.en = en; v.tick = tick; v.ack = a; v.snz = s;
        v.trig = trig; v.idx = idx; v.pend = pend; v.tmo = tmo; v.snzo = snzo;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic trig, input logic [1:0] idx,
                           input logic [3:0] pend, input logic tmo, input logic snzo);
        chk({nm, ".trigger"},    32'(trigger),    32'(trig));
        chk({nm, ".active_idx"}, 32'(active_idx), 32'(idx));
        chk({nm, ".pending"},    32'(pending),    32'(pend));
        chk({nm, ".timed_out"},  32'(timed_out),  32'(tmo));
        chk({nm, ".snoozing"},   32'(snoozing),   32'(snzo));
    endtask

    initial begin
        // cur_time       en     tk ak sz | trig idx pend  tmo snz
        add(16'h0729, 4'b0001, 0, 0, 0,   0, 0, 4'b0000, 0, 0);
        add(16'h0730, 4'b0001, 0, 0, 0,   0, 0, 4'b0001, 0, 0);
        add(16'h0730, 4'b0001, 0, 0, 0,   1, 0, 4'b0000, 0, 0);
        add(16'h0730, 4'b0001, 0, 0, 0,   1, 0, 4'b0000, 0, 0);
        add(16'h0730, 4'b0001, 0, 1, 0,   0, 0, 4'b0000, 0, 0);
        add(16'h0730, 4'b0001, 0, 0, 0,   0, 0, 4'b0000, 0, 0);
        add(16'h0731, 4'b0001, 0, 0, 0,   0, 0, 4'b0000, 0, 0);
        add(16'h0730, 4'b0001, 0, 0, 0,   0, 0, 4'b0001, 0, 0);
        add(16'h0730, 4'b0001, 0, 0, 0,   1, 0, 4'b0000, 0, 0);
        // ring timeout after three minute ticks
        add(16'h0730, 4'b0001, 1, 0, 0,   1, 0, 4'b0000, 0, 0);
        add(16'h0730, 4'b0001, 0, 0, 0,   1, 0, 4'b0000, 0, 0);
        add(16'h0730, 4'b0001, 1, 0, 0,   1, 0, 4'b0000, 0, 0);
        add(16'h0730, 4'b0001, 1, 0, 0,   0, 0, 4'b0000, 1, 0);
        add(16'h0730, 4'b0001, 0, 0, 0,   0, 0, 4'b0000, 0, 0);
        // simultaneous ch1/ch2, lowest index first
        add(16'h1200, 4'b0110, 0, 0, 0,   0, 0, 4'b0110, 0, 0);
        add(16'h1200, 4'b0110, 0, 0, 0,   1, 1, 4'b0100, 0, 0);
        add(16'h1200, 4'b0110, 0, 1, 0,   0, 0, 4'b0100, 0, 0);
        add(16'h1200, 4'b0110, 0, 0, 0,   1, 2, 4'b0000, 0, 0);
`ifdef ALARM_SNOOZE_EN
        add(16'h1200, 4'b0110, 0, 0, 1,   0, 2, 4'b0000, 0, 1);
        for (int k = 0; k < 4; k++)
            add(16'h1200, 4'b0110, 1, 0, 0, 0, 2, 4'b0000, 0, 1);
        add(16'h1200, 4'b0110, 1, 0, 0,   1, 2, 4'b0000, 0, 0);
        add(16'h1200, 4'b0110, 0, 0, 1,   0, 2, 4'b0000, 0, 1);
        add(16'h1200, 4'b0110, 0, 1, 0,   0, 0, 4'b0000, 0, 0);
`else
        add(16'h1200, 4'b0110, 0, 0, 1,   1, 2, 4'b0000, 0, 0);
        add(16'h1200, 4'b0110, 1, 0, 1,   1, 2, 4'b0000, 0, 0);
        add(16'h1200, 4'b0110, 0, 1, 0,   0, 0, 4'b0000, 0, 0);
`endif
        // enable onto current minute, then disable pending and active channels
        add(16'h0730, 4'b0001, 0, 0, 0,   0, 0, 4'b0001, 0, 0);
        add(16'h0730, 4'b0001, 0, 0, 0,   1, 0, 4'b0000, 0, 0);
        add(16'h2359, 4'b1001, 0, 0, 0,   1, 0, 4'b1000, 0, 0);
        add(16'h2359, 4'b0001, 0, 0, 0,   1, 0, 4'b0000, 0, 0);
        add(16'h2359, 4'b0000, 0, 0, 0,   0, 0, 4'b0000, 0, 0);

        alarm_time = {16'h2359, 16'h1200, 16'h1200, 16'h0730};
        cur_time   = 16'h0729;
        alarm_en   = 4'b0001;
        min_tick   = 1'b0;
        ack        = 1'b0;
        snooze     = 1'b0;
        reset_     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 4'b0000, 0, 0);
        reset_ = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cur_time = vecs[i].t;
            alarm_en = vecs[i].en;
            min_tick = vecs[i].tick;
            ack      = vecs[i].ack;
            snooze   = vecs[i].snz;
            @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i), vecs[i].trig, vecs[i].idx,
                    vecs[i].pend, vecs[i].tmo, vecs[i].snzo);
        end

        // asynchronous reset while ringing with another event queued
        cur_time = 16'h1200;
        alarm_en = 4'b0110;
        min_tick = 1'b0;
        ack      = 1'b0;
        snooze   = 1'b0;
        @(posedge clk); #1;
        chk_all("pre_rst0", 0, 0, 4'b0110, 0, 0);
        @(posedge clk); #1;
        chk_all("pre_rst1", 1, 1, 4'b0100, 0, 0);
        #2;
        reset_ = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 4'b0000, 0, 0);
        @(posedge clk); #1;
        chk_all("held_rst", 0, 0, 4'b0000, 0, 0);
        reset_ = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alarm_sched.md
Name: alarm_sched

Overview:
- Multi-channel alarm scheduler for the digital clock. Compares the current BCD time (HH:MM, 4 digits) against N_ALARMS programmable alarm times.
- Queues alarm events and drives a single ring output through a small FSM with acknowledge, optional snooze and auto-timeout.
- Sits between the timekeeping counter (time digits, minute tick) and the buzzer/LED driver.

Parameters:
- N_ALARMS, 4, number of independent alarm channels (1..16).
- RING_MIN, 3, minutes an alarm rings unacknowledged before auto-stop (1..15).
- SNOOZE_MIN, 5, snooze length in minutes (1..15).

Ports:
- clk  in  1  system clock.
- reset_  in  1  asynchronous active-low reset.
- cur_time  in  16  current time, BCD digits {d3,d2,d1,d0}.
- min_tick  in  1  one-cycle pulse at each minute rollover.
- alarm_time  in  16*N_ALARMS  alarm i time at bits [16i+15:16i], same digit order.
- alarm_en  in  N_ALARMS  per-channel enable.
- ack  in  1  user stop/acknowledge, level-sampled.
- snooze  in  1  user snooze request, level-sampled.
- trigger  out  1  buzzer drive, high while RINGING.
- snoozing  out  1  high while SNOOZE.
- active_idx  out  max(1,$clog2(N_ALARMS))  channel being serviced; 0 in IDLE.
- pending  out  N_ALARMS  queued, unserviced events.
- timed_out  out  1  one-cycle pulse when ringing ends by timeout.

Behaviour:
- Reset: FSM=IDLE. trigger, snoozing, active_idx, pending, timed_out, ring/snooze counters and match history all 0.
- Match: match[i] = alarm_en[i] && all 4 digits of cur_time equal alarm_time[i]. Register match_q[i].
- Event on rising edge match[i] & ~match_q[i] sets pending[i]. This fires once per matching minute, including when an alarm is programmed or enabled onto the current minute.
- pending[i] clears when channel i is dispatched, or when alarm_en[i] is 0.
- FSM states: IDLE, RINGING, SNOOZE. All outputs are registered.
- IDLE:
  - If pending != 0: go to RINGING. active_idx = lowest set index; clear that pending bit in the same cycle; ring_cnt = 0.
  - trigger rises the cycle after the event edge is registered (2 clk after match asserts).
- RINGING (priorities, highest first):
  - ack: go to IDLE.
  - alarm_en[active_idx]=0: go to IDLE (cancel).
  - snooze: go to SNOOZE, snz_cnt = SNOOZE_MIN.
  - min_tick: ring_cnt++. If ring_cnt+1 == RING_MIN, go to IDLE and pulse timed_out.
- SNOOZE (priorities, highest first):
  - ack or alarm_en[active_idx]=0: go to IDLE.
  - min_tick: snz_cnt--. When it reaches 0, go to RINGING with ring_cnt = 0.
- New events while RINGING or SNOOZE only set pending. They are dispatched from IDLE in lowest-index-first order, one per IDLE visit; back-to-back dispatch needs exactly one IDLE cycle.
- Same-cycle event and dispatch clear on one bit: set wins, so the bit stays pending.
- Counters are 4-bit and saturate; they never wrap.
- Asynchronous reset mid-ring returns to IDLE immediately and drops all pending events.

Optional Feature:
- ALARM_SNOOZE_EN defined: SNOOZE state, snoozing output and the snooze input are active as described.
- Not defined: snooze input is ignored, snoozing is tied 0, SNOOZE state and snz_cnt are not built, and SNOOZE_MIN is unused.

Decomposition:
- Shared package alarm_pkg holds:
  - state encoding typedef (IDLE=2'd0, RINGING=2'd1, SNOOZE=2'd2);
  - TIME_W=16 and DIGIT_W=4 constants;
  - a lowest-set-bit priority function.
- One natural sub-module: alarm_match_chan, instantiated N_ALARMS times. It holds the compare, match_q register, edge detect and pending bit for one channel.

Test Plan:
- Reset then wait: alarm_time[0]=0x0730, en=0001, cur_time steps 0x0729→0x0730. Expect trigger=1 two cycles after the step, active_idx=0, pending=0.
- Ring then ack: with trigger high, pulse ack. Expect trigger=0 next cycle. Holding cur_time=0x0730 does not re-fire. 0x0731→0x0730 wrap via a new day does fire.
- Timeout: RING_MIN=3, no ack, three min_tick pulses. Expect timed_out pulse and trigger=0 on the third tick, return to IDLE.
- Simultaneous channels: ch1 and ch2 both 0x1200. Expect ch1 serviced first (active_idx=1, pending=0100). After ack, one IDLE cycle, then active_idx=2 ringing.
- Snooze (ALARM_SNOOZE_EN): snooze while ringing, SNOOZE_MIN=5. Expect snoozing=1, trigger=0, and ringing resumes on the 5th min_tick. ack during SNOOZE returns to IDLE. Without the macro, snooze has no effect.
- Disable mid-ring: clear alarm_en[active_idx] while RINGING. Expect IDLE and trigger=0 next cycle, with that channel's pending bit cleared. Also assert reset_ low mid-ring: all outputs 0 immediately.
